store_unit: RTL and testbench
=============================

Name: store_unit

Overview:
- Executes the memory-write side of S-type stores.
- Takes the decoded store-size select (2-bit, same encoding as the S-type decoder output), byte address and rs2 data from the execute stage.
- Produces a word-aligned, byte-strobed write request to data memory with a req/ack handshake.
- Reports completion, misalignment and bus timeout back to the pipeline.

Parameters:
- ADDR_W, 32, byte-address width
- TIMEOUT_CYC, 255, max cycles waiting for mem_ack before abort; 0 = wait forever
- CNT_W, 8, width of timeout counter; must satisfy TIMEOUT_CYC < 2^CNT_W

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- st_valid  in  1  store request from execute stage
- st_ready  out  1  unit can accept a store this cycle
- st_sel  in  2  size select: 00=word (SW), 01=half (SH), 10=byte (SB), 11=illegal
- st_addr  in  ADDR_W  byte address
- st_data  in  32  rs2 value, low-aligned
- st_done  out  1  one-cycle pulse: store completed successfully
- st_err  out  1  one-cycle pulse: store aborted (misalign, illegal sel, or timeout)
- st_err_code  out  2  valid with st_err: 01=misalign, 10=illegal sel, 11=timeout
- mem_req  out  1  write request to data memory
- mem_addr  out  ADDR_W  word-aligned address (st_addr with [1:0]=0)
- mem_wdata  out  32  lane-replicated write data
- mem_wstrb  out  4  byte enables
- mem_ack  in  1  memory accepted write

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - While rst is high, on each clk edge: state=IDLE, counter=0, all outputs 0 except st_ready=1 after the first post-reset cycle.
  - mem_addr, mem_wdata and mem_wstrb reset to 0.
- FSM states and transitions:
  - IDLE: st_ready=1. A store is accepted on st_valid&&st_ready; inputs are registered.
    - Illegal sel (11) -> ERR with code 10.
    - Misaligned -> ERR with code 01. Half is misaligned when addr[0]=1; word is misaligned when addr[1:0]!=0.
    - Otherwise -> REQ.
  - REQ: mem_req=1, payload held stable until ack; st_ready=0.
    - mem_ack -> DONE.
    - counter reaches TIMEOUT_CYC (when TIMEOUT_CYC!=0) -> ERR with code 11.
    - Counter increments each REQ cycle without ack and clears on REQ entry.
  - DONE: st_done=1 for one cycle -> IDLE.
  - ERR: st_err=1 with code for one cycle; mem_req=0 -> IDLE.
- Latency: accept at cycle 0; mem_req asserted from cycle 1; with ack in the same cycle, st_done in cycle 2. Minimum store-to-store throughput is 3 cycles.
- Lane generation (off = addr[1:0]):
  - word: wstrb=1111, wdata=data.
  - half: wstrb=0011<<off, wdata={2{data[15:0]}}.
  - byte: wstrb=0001<<off, wdata={4{data[7:0]}}.
- Error cases never raise mem_req; mem_wstrb=0 whenever mem_req=0.
- An ack in the same cycle the counter hits the limit counts as success; ack wins.
- mem_ack while not in REQ is ignored.
- Reset during REQ: mem_req drops on the next edge, no st_done/st_err pulse, memory-side transaction is abandoned.
- st_valid while st_ready=0 is not accepted; upstream must hold it.

Optional Feature:
- Macro: STORE_MISALIGN_SPLIT_EN.
- Defined: misaligned half/word stores are not trapped. They are executed as two sequential REQ phases (states REQ_LO, REQ_HI):
  - REQ_LO writes the bytes in the addressed word.
  - REQ_HI writes the remaining bytes at mem_addr+4 with wstrb shifted in from bit 0 and data rotated accordingly.
  - st_done pulses after the second ack.
  - Timeout in either phase -> ERR 11; the first half may already be written.
- Undefined: misalign traps with code 01 as above.

Decomposition:
- Shared package store_pkg:
  - st_sel encodings: ST_W=2'b00, ST_H=2'b01, ST_B=2'b10.
  - Error codes: ERR_MIS, ERR_ILL, ERR_TMO.
  - FSM state enum.
- The S-type decoder and this unit both use the st_sel constants.
- One natural sub-module: store_lane_gen, purely combinational: sel, off, data -> wstrb, wdata, misalign, illegal.

Test Plan:
- SB addr 0x1003 data 0xAB, ack on first REQ cycle -> mem_addr 0x1000, wstrb 1000, wdata 0xABABABAB, st_done 2 cycles after accept.
- SH addr 0x2002 data 0x1234BEEF, ack after 3 wait cycles -> wstrb 1100, wdata 0xBEEFBEEF held stable 4 cycles, single st_done.
- SW addr 0x3001 -> no mem_req, st_err with code 01. With SPLIT_EN instead:
  - first request 0x3000, wstrb 1110;
  - second request 0x3004, wstrb 0001;
  - one st_done.
- st_sel=11 -> st_err code 10, no mem_req; st_ready back to 1 the following cycle.
- TIMEOUT_CYC=4, ack never asserted -> mem_req high exactly 4 cycles, then st_err code 11.
- Ack on the timeout cycle -> st_done, no st_err.
- rst asserted mid-REQ -> mem_req 0 next edge, no done/err pulse, st_ready 1 after reset release; next store proceeds normally.

Source files
------------

// File: rtl/store_pkg.sv
// Shared store-size encodings, error codes and FSM states for the store path.
// STORE_MISALIGN_SPLIT_EN adds the second (high-word) request phase.
package store_pkg;

    localparam logic [1:0] ST_W = 2'b00;
    localparam logic [1:0] ST_H = 2'b01;
    localparam logic [1:0] ST_B = 2'b10;

    localparam logic [1:0] ERR_MIS = 2'b01;
    localparam logic [1:0] ERR_ILL = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;

    // S_REQ doubles as the low-word phase when split stores are enabled
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
`ifdef STORE_MISALIGN_SPLIT_EN
        S_REQ_HI,
`endif
        S_DONE,
        S_ERR
    } state_e;

endpackage

// File: rtl/store_lane_gen.sv
// Combinational lane steering: size/offset/data -> byte strobes, write data, fault flags.
// With STORE_MISALIGN_SPLIT_EN, also yields the strobes spilling into the next word.
module store_lane_gen
    import store_pkg::*;
(
    input  logic [1:0]  sel_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] data_i,
    output logic [3:0]  wstrb_o,
`ifdef STORE_MISALIGN_SPLIT_EN
    output logic [3:0]  wstrb_hi_o,
`endif
    output logic [31:0] wdata_o,
    output logic        misalign_o,
    output logic        illegal_o
);

    logic [3:0] base;
`ifdef STORE_MISALIGN_SPLIT_EN
    logic [7:0] span;
    logic [5:0] sh;
`endif

    always_comb begin
        base    = '0;
        wdata_o = '0;
        case (sel_i)
            ST_W: begin base = 4'b1111; wdata_o = data_i;               end
            ST_H: begin base = 4'b0011; wdata_o = {2{data_i[15:0]}};    end
            ST_B: begin base = 4'b0001; wdata_o = {4{data_i[7:0]}};     end
            default: ;
        endcase
        illegal_o  = (sel_i == 2'b11);
        misalign_o = ((sel_i == ST_H) && off_i[0]) || ((sel_i == ST_W) && (off_i != 2'b00));
`ifdef STORE_MISALIGN_SPLIT_EN
        span       = {4'b0000, base} << off_i;
        wstrb_o    = span[3:0];
        wstrb_hi_o = span[7:4];
        sh         = {1'b0, off_i, 3'b000};
        // rotated data serves both words: low lanes land in the high word
        if (misalign_o)
            wdata_o = (data_i << sh) | (data_i >> (6'd32 - sh));
`else
        wstrb_o    = base << off_i;
`endif
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts S-type stores, issues a byte-strobed word write with req/ack.
// Define STORE_MISALIGN_SPLIT_EN to execute misaligned stores as two word writes.
module store_unit
    import store_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [1:0]        st_sel,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    output logic              st_done,
    output logic              st_err,
    output logic [1:0]        st_err_code,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [1:0]        code_q, code_d;
`ifdef STORE_MISALIGN_SPLIT_EN
    logic [3:0]        hi_q, hi_d;
    logic [3:0]        lg_wstrb_hi;
`endif

    logic [3:0]  lg_wstrb;
    logic [31:0] lg_wdata;
    logic        lg_mis, lg_ill, trap_mis, timeout;

    store_lane_gen u_lane (
        .sel_i      (st_sel),
        .off_i      (st_addr[1:0]),
        .data_i     (st_data),
        .wstrb_o    (lg_wstrb),
`ifdef STORE_MISALIGN_SPLIT_EN
        .wstrb_hi_o (lg_wstrb_hi),
`endif
        .wdata_o    (lg_wdata),
        .misalign_o (lg_mis),
        .illegal_o  (lg_ill)
    );

`ifdef STORE_MISALIGN_SPLIT_EN
    assign trap_mis = 1'b0;
`else
    assign trap_mis = lg_mis;
`endif

    assign timeout = (TIMEOUT_CYC != 0) && (cnt_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        code_d  = code_q;
`ifdef STORE_MISALIGN_SPLIT_EN
        hi_d    = hi_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (st_valid) begin
                    if (lg_ill) begin
                        code_d  = ERR_ILL;
                        state_d = S_ERR;
                    end else if (trap_mis) begin
                        code_d  = ERR_MIS;
                        state_d = S_ERR;
                    end else begin
                        addr_d  = {st_addr[ADDR_W-1:2], 2'b00};
                        wdata_d = lg_wdata;
                        wstrb_d = lg_wstrb;
                        cnt_d   = '0;
`ifdef STORE_MISALIGN_SPLIT_EN
                        hi_d    = lg_wstrb_hi;
`endif
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // ack beats a simultaneous timeout
                if (mem_ack) begin
                    state_d = S_DONE;
`ifdef STORE_MISALIGN_SPLIT_EN
                    if (hi_q != 4'b0000) begin
                        addr_d  = addr_q + ADDR_W'(4);
                        wstrb_d = hi_q;
                        cnt_d   = '0;
                        state_d = S_REQ_HI;
                    end
`endif
                end else if (timeout) begin
                    code_d  = ERR_TMO;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef STORE_MISALIGN_SPLIT_EN
            S_REQ_HI: begin
                if (mem_ack) begin
                    state_d = S_DONE;
                end else if (timeout) begin
                    code_d  = ERR_TMO;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            code_q  <= '0;
`ifdef STORE_MISALIGN_SPLIT_EN
            hi_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            code_q  <= code_d;
`ifdef STORE_MISALIGN_SPLIT_EN
            hi_q    <= hi_d;
`endif
        end
    end

`ifdef STORE_MISALIGN_SPLIT_EN
    assign mem_req = (state_q == S_REQ) || (state_q == S_REQ_HI);
`else
    assign mem_req = (state_q == S_REQ);
`endif
    assign st_ready    = (state_q == S_IDLE);
    assign st_done     = (state_q == S_DONE);
    assign st_err      = (state_q == S_ERR);
    assign st_err_code = (state_q == S_ERR) ? code_q : 2'b00;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_wstrb   = mem_req ? wstrb_q : 4'b0000;

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: random stores against a byte-lane reference model.
module tb_store_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [1:0]  st_sel = '0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        st_done, st_err;
    logic [1:0]  st_err_code;
    logic        mem_req;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;

    store_unit #(.ADDR_W(32), .TIMEOUT_CYC(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
        .st_sel(st_sel), .st_addr(st_addr), .st_data(st_data),
        .st_done(st_done), .st_err(st_err), .st_err_code(st_err_code),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [1:0]  code;
        bit          has_req;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          reqcyc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference: each byte lane k is written when off <= k < off+size and carries data byte k%size.
    function automatic exp_t model(input logic [1:0] sel, input logic [31:0] addr,
                                   input logic [31:0] data, input int d);
        exp_t e;
        int size, off;
        e = '{err: 0, code: 2'b00, has_req: 0, addr: '0, wdata: '0, wstrb: '0, reqcyc: 0, lat: 0};
        off  = int'(addr[1:0]);
        size = (sel == 2'b00) ? 4 : (sel == 2'b01) ? 2 : (sel == 2'b10) ? 1 : 0;
        if (size == 0) begin
            e.err = 1; e.code = 2'b10; e.lat = 1;
        end else if (off % size != 0) begin
            e.err = 1; e.code = 2'b01; e.lat = 1;
        end else begin
            e.has_req = 1;
            e.addr    = addr & 32'hFFFF_FFFC;
            for (int k = 0; k < 4; k++) begin
                e.wstrb[k]       = (k >= off) && (k < off + size);
                e.wdata[8*k +: 8] = data[8*(k % size) +: 8];
            end
            if (d + 1 <= TMO) begin
                e.reqcyc = d + 1;
                e.lat    = d + 2;
            end else begin
                e.err = 1; e.code = 2'b11; e.reqcyc = TMO; e.lat = TMO + 1;
            end
        end
        return e;
    endfunction

    // d = wait cycles before ack; d >= TMO means ack never comes
    task automatic issue(input logic [1:0] sel, input logic [31:0] addr, input logic [31:0] data,
                         input int d, input bit rst_mid);
        exp_t e;
        int   guard;
        e = model(sel, addr, data, d);
        exp_q.push_back(e);
        mem_ack  = 1'($urandom % 2);
        st_valid = 1'b1; st_sel = sel; st_addr = addr; st_data = data;
        guard = 0;
        while (!st_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (!st_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept_bound: st_ready stayed %0b, required 1", st_ready);
            void'(exp_q.pop_back());
            st_valid = 1'b0; mem_ack = 1'b0;
            return;
        end
        @(posedge clk); #1;
        st_valid = 1'b0;
        mem_ack  = 1'b0;
        if (e.has_req) begin
            if (rst_mid) begin
                @(posedge clk); #1;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            for (int c = 1; c <= e.reqcyc; c++) begin
                mem_ack = (e.code != 2'b11) && (c == e.reqcyc);
                @(posedge clk); #1;
            end
            mem_ack = 1'b0;
        end
        repeat ($urandom_range(0, 2)) begin
            mem_ack = 1'($urandom % 2);
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
    endtask

    int   cyc = 0;
    int   reqcnt = 0;
    bit   rst_prev = 0;
    bit   pulse_prev = 0;
    exp_t me;
    int   acc;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete(); acc_q.delete();
            reqcnt = 0; rst_prev = 1; pulse_prev = 0;
        end else begin
            if (rst_prev) begin
                chk("rst_mem_req",   mem_req,     1'b0);
                chk("rst_done",      st_done,     1'b0);
                chk("rst_err",       st_err,      1'b0);
                chk("rst_ready",     st_ready,    1'b1);
                chk("rst_mem_addr",  mem_addr,    32'h0);
                chk("rst_mem_wdata", mem_wdata,   32'h0);
                chk("rst_err_code",  st_err_code, 2'b00);
                rst_prev = 0;
            end
            if (pulse_prev) chk("ready_after_pulse", st_ready, 1'b1);
            pulse_prev = 0;
            if (st_valid && st_ready) acc_q.push_back(cyc);
            if (!mem_req) chk("wstrb_idle", mem_wstrb, 4'b0000);
            if (mem_req) begin
                reqcnt++;
                if (exp_q.size() == 0 || !exp_q[0].has_req) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_req: mem_req=1 addr %0h, required no request", mem_addr);
                end else begin
                    chk("mem_addr",  mem_addr,  exp_q[0].addr);
                    chk("mem_wdata", mem_wdata, exp_q[0].wdata);
                    chk("mem_wstrb", mem_wstrb, exp_q[0].wstrb);
                end
            end
            if (st_done || st_err) begin
                pulse_prev = 1;
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_pulse: done=%0b err=%0b, required none", st_done, st_err);
                end else begin
                    me  = exp_q.pop_front();
                    acc = acc_q.pop_front();
                    chk("st_done",     st_done,     !me.err);
                    chk("st_err",      st_err,      me.err);
                    chk("st_err_code", st_err_code, me.err ? me.code : 2'b00);
                    chk("latency",     cyc - acc,   me.lat);
                    chk("req_cycles",  reqcnt,      me.has_req ? me.reqcyc : 0);
                end
                reqcnt = 0;
            end
        end
    end

    initial begin
        int g;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        issue(2'b10, 32'h0000_1003, 32'h0000_00AB, 0, 0);
        issue(2'b01, 32'h0000_2002, 32'h1234_BEEF, 3, 0);
        issue(2'b00, 32'h0000_3001, 32'hDEAD_BEEF, 0, 0);
        issue(2'b11, 32'h0000_4000, 32'h1111_2222, 0, 0);
        issue(2'b00, 32'h0000_5000, 32'hCAFE_F00D, TMO + 1, 0);
        issue(2'b00, 32'h0000_6004, 32'h0BAD_CAFE, TMO - 1, 0);
        issue(2'b01, 32'h0000_7000, 32'h5555_AAAA, TMO + 1, 1);
        issue(2'b00, 32'h0000_8000, 32'h8765_4321, 1, 0);

        for (int i = 0; i < 200; i++)
            issue(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(0, TMO + 1), 0);

        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(posedge clk); g++;
        end
        if (exp_q.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain: %0d stores outstanding, required 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
